// File: rtl/bus_router3_pkg.sv
// rtl/bus_router3_pkg.sv - shared region codes, target selects and FSM states for bus_router3
package bus_router3_pkg;

   localparam logic [3:0] REG_TMR = 4'hF;
   localparam logic [3:0] REG_IO  = 4'hE;
   localparam logic [3:0] REG_BAD = 4'hD;

   localparam logic [1:0] SEL_MEM  = 2'b00;
   localparam logic [1:0] SEL_IO   = 2'b01;
   localparam logic [1:0] SEL_TMR  = 2'b10;
   localparam logic [1:0] SEL_NONE = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_WAIT = 2'b01,
      ST_RESP = 2'b10
   } state_t;

   // SEL_NONE maps to no request line at all
   function automatic logic [2:0] sel_onehot(input logic [1:0] sel);
      logic [2:0] oh;
      oh = 3'b000;
      case (sel)
         SEL_MEM: oh = 3'b001;
         SEL_IO:  oh = 3'b010;
         SEL_TMR: oh = 3'b100;
         default: oh = 3'b000;
      endcase
      return oh;
   endfunction

endpackage

// File: rtl/bus_addr_decode.sv
// rtl/bus_addr_decode.sv - top address nibble to target select and unmapped flag
module bus_addr_decode
   import bus_router3_pkg::*;
(
   input  logic [3:0] i_region,
   output logic [1:0] o_sel,
   output logic       o_unmapped
);

   always_comb begin
      o_sel      = SEL_MEM;
      o_unmapped = 1'b0;
      case (i_region)
         REG_TMR: o_sel = SEL_TMR;
         REG_IO:  o_sel = SEL_IO;
         REG_BAD: begin
            o_sel      = SEL_NONE;
            o_unmapped = 1'b1;
         end
         default: o_sel = SEL_MEM;
      endcase
   end

endmodule

// File: rtl/bus_router3.sv
// rtl/bus_router3.sv - routes one CPU load/store to memory, I/O or timer with req/ack and timeout
module bus_router3
   import bus_router3_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int TIMEOUT = 15
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cpu_req,
   input  logic             cpu_we,
   input  logic [WIDTH-1:0] cpu_addr,
   input  logic [WIDTH-1:0] cpu_wdata,
   output logic             cpu_ready,
   output logic [WIDTH-1:0] cpu_rdata,
   output logic             cpu_err,
   output logic [1:0]       rsel,
   output logic [2:0]       s_req,
   output logic             s_we,
   output logic [WIDTH-1:0] s_addr,
   output logic [WIDTH-1:0] s_wdata,
   input  logic [2:0]       s_ack,
   input  logic [WIDTH-1:0] s_rdata0,
   input  logic [WIDTH-1:0] s_rdata1,
   input  logic [WIDTH-1:0] s_rdata2
);

   localparam int            CW     = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] TO_CNT = CW'(TIMEOUT);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CW-1:0]    r_cnt;
   logic             r_we;
   logic [WIDTH-1:0] r_addr;
   logic [WIDTH-1:0] r_wdata;
   logic [1:0]       r_sel;
   logic [WIDTH-1:0] r_rdata;
   logic             r_err;

   logic [1:0]       w_sel;
   logic             w_unmapped;
   logic             w_ack_sel;
   logic             w_timeout;
   logic [WIDTH-1:0] w_rdata_mux;

   bus_addr_decode u_decode (
      .i_region   (cpu_addr[WIDTH-1 -: 4]),
      .o_sel      (w_sel),
      .o_unmapped (w_unmapped)
   );

   // Only the latched target's ack counts; strays from other targets are masked
   assign w_ack_sel = |(s_ack & sel_onehot(r_sel));
   assign w_timeout = (r_cnt == TO_CNT);

   always_comb begin
      w_rdata_mux = '0;
      case (r_sel)
         SEL_MEM: w_rdata_mux = s_rdata0;
         SEL_IO:  w_rdata_mux = s_rdata1;
         SEL_TMR: w_rdata_mux = s_rdata2;
         default: w_rdata_mux = '0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = ST_IDLE;
      case (r_state)
         ST_IDLE: begin
            if (cpu_req) begin
               w_state_nxt = w_unmapped ? ST_RESP : ST_WAIT;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (w_ack_sel || w_timeout) begin
               w_state_nxt = ST_RESP;
            end else begin
               w_state_nxt = ST_WAIT;
            end
         end
         ST_RESP: w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt   <= '0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_sel   <= SEL_MEM;
         r_rdata <= '0;
         r_err   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_cnt <= '0;
               if (cpu_req) begin
                  r_we    <= cpu_we;
                  r_addr  <= cpu_addr;
                  r_wdata <= cpu_wdata;
                  r_sel   <= w_sel;
                  if (w_unmapped) begin
                     r_err   <= 1'b1;
                     r_rdata <= '0;
                  end
               end
            end
            ST_WAIT: begin
               r_cnt <= r_cnt + CW'(1);
               // An ack arriving on the timeout cycle still completes cleanly
               if (w_ack_sel) begin
                  r_err   <= 1'b0;
                  r_rdata <= r_we ? '0 : w_rdata_mux;
               end else if (w_timeout) begin
                  r_err   <= 1'b1;
                  r_rdata <= '0;
               end
            end
            default: r_cnt <= '0;
         endcase
      end
   end

   assign cpu_ready = (r_state == ST_RESP);
   assign cpu_err   = r_err & cpu_ready;
   assign cpu_rdata = r_rdata;
   assign rsel      = r_sel;
   assign s_req     = (r_state == ST_WAIT) ? sel_onehot(r_sel) : 3'b000;
   assign s_we      = r_we;
   assign s_addr    = r_addr;
   assign s_wdata   = r_wdata;

endmodule

// File: tb/tb_bus_router3.sv
// tb/tb_bus_router3.sv - directed self-checking bench for bus_router3
module tb_bus_router3;

   logic        clk;
   logic        reset;
   logic        cpu_req;
   logic        cpu_we;
   logic [31:0] cpu_addr;
   logic [31:0] cpu_wdata;
   logic        cpu_ready;
   logic [31:0] cpu_rdata;
   logic        cpu_err;
   logic [1:0]  rsel;
   logic [2:0]  s_req;
   logic        s_we;
   logic [31:0] s_addr;
   logic [31:0] s_wdata;
   logic [2:0]  s_ack;
   logic [31:0] s_rdata0;
   logic [31:0] s_rdata1;
   logic [31:0] s_rdata2;

   int checks   = 0;
   int failures = 0;
   int n;

   bus_router3 #(.WIDTH(32), .TIMEOUT(15)) dut (
      .clk       (clk),
      .reset     (reset),
      .cpu_req   (cpu_req),
      .cpu_we    (cpu_we),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_ready (cpu_ready),
      .cpu_rdata (cpu_rdata),
      .cpu_err   (cpu_err),
      .rsel      (rsel),
      .s_req     (s_req),
      .s_we      (s_we),
      .s_addr    (s_addr),
      .s_wdata   (s_wdata),
      .s_ack     (s_ack),
      .s_rdata0  (s_rdata0),
      .s_rdata1  (s_rdata1),
      .s_rdata2  (s_rdata2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   initial begin
      reset     = 1'b1;
      cpu_req   = 1'b0;
      cpu_we    = 1'b0;
      cpu_addr  = '0;
      cpu_wdata = '0;
      s_ack     = 3'b000;
      s_rdata0  = '0;
      s_rdata1  = '0;
      s_rdata2  = '0;
      tick;
      tick;
      check("rst_ready", cpu_ready, 0);
      check("rst_sreq", s_req, 0);
      check("rst_rsel", rsel, 0);
      check("rst_rdata", cpu_rdata, 0);
      check("rst_err", cpu_err, 0);
      check("rst_swe", s_we, 0);
      reset = 1'b0;
      tick;

      // load to data memory, ack in first WAIT cycle
      cpu_addr = 32'h0000_0010; cpu_we = 1'b0; cpu_req = 1'b1;
      s_rdata0 = 32'hDEAD_BEEF;
      tick;
      cpu_req = 1'b0;
      check("t1_sreq", s_req, 3'b001);
      check("t1_ready_early", cpu_ready, 0);
      check("t1_saddr", s_addr, 32'h0000_0010);
      s_ack = 3'b001;
      tick;
      s_ack = 3'b000;
      check("t1_ready", cpu_ready, 1);
      check("t1_rdata", cpu_rdata, 32'hDEAD_BEEF);
      check("t1_err", cpu_err, 0);
      check("t1_rsel", rsel, 2'b00);
      check("t1_sreq_resp", s_req, 0);
      tick;
      check("t1_ready_pulse", cpu_ready, 0);

      // store to I/O, ack after three WAIT cycles
      cpu_addr = 32'hE000_0004; cpu_we = 1'b1; cpu_wdata = 32'h55; cpu_req = 1'b1;
      s_rdata1 = 32'hAAAA_5555;
      tick;
      cpu_req = 1'b0;
      check("t2_swe", s_we, 1);
      check("t2_swdata", s_wdata, 32'h55);
      check("t2_saddr", s_addr, 32'hE000_0004);
      n = 0;
      while (s_req == 3'b010 && n < 3) begin
         n++;
         if (n == 3) s_ack = 3'b010;
         check("t2_noready_wait", cpu_ready, 0);
         tick;
      end
      s_ack = 3'b000;
      check("t2_sreq_cycles", n, 3);
      check("t2_ready", cpu_ready, 1);
      check("t2_err", cpu_err, 0);
      check("t2_rdata_store", cpu_rdata, 0);
      check("t2_rsel", rsel, 2'b01);
      tick;

      // unmapped region
      cpu_addr = 32'hD000_0000; cpu_we = 1'b0; cpu_req = 1'b1;
      tick;
      cpu_req = 1'b0;
      check("t3_ready", cpu_ready, 1);
      check("t3_err", cpu_err, 1);
      check("t3_rdata", cpu_rdata, 0);
      check("t3_rsel", rsel, 2'b11);
      check("t3_sreq", s_req, 0);
      tick;
      check("t3_ready_pulse", cpu_ready, 0);

      // timer: ack on the cycle the counter reaches TIMEOUT
      cpu_addr = 32'hF000_0000; cpu_req = 1'b1;
      s_rdata2 = 32'hCAFE_F00D;
      tick;
      cpu_req = 1'b0;
      repeat (15) tick;
      check("t5_sreq_last", s_req, 3'b100);
      s_ack = 3'b100;
      tick;
      s_ack = 3'b000;
      check("t5_ready", cpu_ready, 1);
      check("t5_err", cpu_err, 0);
      check("t5_rdata", cpu_rdata, 32'hCAFE_F00D);
      tick;

      // timer: no ack, timeout after 16 WAIT cycles
      cpu_addr = 32'hF000_0000; cpu_req = 1'b1;
      tick;
      cpu_req = 1'b0;
      n = 0;
      while (s_req == 3'b100 && n < 40) begin
         n++;
         tick;
      end
      check("t4_sreq_cycles", n, 16);
      check("t4_ready", cpu_ready, 1);
      check("t4_err", cpu_err, 1);
      check("t4_rdata", cpu_rdata, 0);
      check("t4_rsel", rsel, 2'b10);
      tick;

      // data memory with stray acks from other targets
      cpu_addr = 32'h0000_0100; cpu_req = 1'b1;
      s_rdata0 = 32'h0BAD_F00D;
      tick;
      cpu_req = 1'b0;
      s_ack = 3'b110;
      tick;
      check("t6_stray1_ready", cpu_ready, 0);
      check("t6_stray1_sreq", s_req, 3'b001);
      s_ack = 3'b010;
      tick;
      check("t6_stray2_ready", cpu_ready, 0);
      s_ack = 3'b001;
      tick;
      s_ack = 3'b000;
      check("t6_ready", cpu_ready, 1);
      check("t6_rdata", cpu_rdata, 32'h0BAD_F00D);
      check("t6_err", cpu_err, 0);
      tick;

      // reset two cycles into WAIT
      cpu_addr = 32'hE000_0020; cpu_req = 1'b1;
      tick;
      cpu_req = 1'b0;
      tick;
      check("t7_sreq_before", s_req, 3'b010);
      tick;
      reset = 1'b1;
      #1;
      check("t7_sreq_async", s_req, 0);
      check("t7_ready_async", cpu_ready, 0);
      check("t7_rsel_async", rsel, 0);
      tick;
      reset = 1'b0;
      n = 0;
      repeat (3) begin
         tick;
         if (cpu_ready) n++;
      end
      check("t7_no_ready", n, 0);
      cpu_addr = 32'h0000_0300; cpu_req = 1'b1;
      s_rdata0 = 32'h1111_2222;
      tick;
      cpu_req = 1'b0;
      check("t7_next_sreq", s_req, 3'b001);
      s_ack = 3'b001;
      tick;
      s_ack = 3'b000;
      check("t7_next_ready", cpu_ready, 1);
      check("t7_next_rdata", cpu_rdata, 32'h1111_2222);
      check("t7_next_err", cpu_err, 0);
      tick;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
